fetch_unit: RTL and testbench
=============================

# fetch_unit

Parametrised, decoupled instruction-fetch front end. It replaces the direct PC-to-memory wiring with a registered PC, a request/response memory handshake, an in-order prefetch buffer of DEPTH entries, and branch/jump redirect with flush. Sits between the instruction memory port and the decoder; the decoder consumes instructions through a valid/ready handshake.

## Interface

- XLEN, 32: instruction and PC width.
- ADDRWIDTH, 32: memory address width (≤ XLEN; low ADDRWIDTH bits of PC are driven).
- DEPTH, 4: prefetch buffer entries; power of 2, ≥ 2.
- RESET_PC, 0: PC loaded on reset.

- clk  in  1  clock, all state on rising edge.
- cpu_rstn  in  1  reset, synchronous, active-low.
- req_valid  out  1  memory read request valid.
- req_ready  in  1  memory accepts request.
- req_addr  out  ADDRWIDTH  request byte address.
- rsp_valid  in  1  read data returned; in order, ≥1 cycle after acceptance, no backpressure.
- rsp_data  in  XLEN  returned instruction word.
- redirect_valid  in  1  PC redirect (taken branch/jump/trap).
- redirect_pc  in  XLEN  redirect target.
- instr_valid  out  1  buffer head valid.
- instr_ready  in  1  decoder consumes head.
- instr_data  out  XLEN  head instruction.
- instr_pc  out  XLEN  head PC.
- instr_misaligned  out  1  head is a misaligned-fetch fault marker.
- occupancy  out  $clog2(DEPTH+1)  entries currently buffered.

## Operation

- State: fetch_pc, inflight counter (accepted, not yet responded), drop counter, FIFO (data, pc, misaligned), FSM {FETCH, FAULT}.
- Credit: req_valid = (state==FETCH) && !redirect_valid && (occupancy + inflight < DEPTH). Guarantees no response ever overflows the buffer.
- Request handshake (req_valid && req_ready): inflight+1, fetch_pc += 4 (wraps modulo 2^XLEN). req_addr = fetch_pc.
- PC of each request is queued alongside inflight (DEPTH-entry tag queue) and attached to its response.
- Response: inflight-1. If drop>0: discard, drop-1. Else push {rsp_data, tag pc, 0}.
- Pop on instr_valid && instr_ready. Push and pop in same cycle: occupancy unchanged.
- Redirect (highest priority): FIFO flushed, drop <= inflight − (rsp_valid ? 1 : 0), rsp in same cycle discarded, fetch_pc <= redirect_pc.
  - redirect_pc[1:0]==0: state FETCH.
  - redirect_pc[1:0]!=0: no request issued; push one entry {0, redirect_pc, 1} in the next cycle; state FAULT.
- FAULT: req_valid=0; remains until next redirect. Stale responses still drained via drop.
- Alignment check is bits [1:0] only.

## Timing

- Reset values: req_valid 0, req_addr RESET_PC[ADDRWIDTH-1:0], instr_valid 0, instr_data 0, instr_pc 0, instr_misaligned 0, occupancy 0; inflight, drop 0; state FETCH.
- Reset mid-operation: all of the above restored in one cycle; memory responses for pre-reset requests are the environment's responsibility (none arrive after reset).
- First req_valid in the first cycle after cpu_rstn rises (if req_ready held, one request per cycle).
- Response at cycle t → instr_valid at t+1 (registered, no bypass).
- Redirect at cycle t → first new request at t+1; fault marker visible at t+1.
- Back-to-back throughput: 1 instr/cycle with single-cycle memory and instr_ready held high.
- instr_* stable while instr_valid && !instr_ready (except flush by redirect).

## Test plan

- Reset, RESET_PC=0x100, 1-cycle memory, instr_ready=1 → req_addr 0x100,0x104,0x108…; instr_pc tracks with one instr/cycle after 2-cycle fill.
- instr_ready=0, DEPTH=4, memory latency 1 → exactly 4 requests accepted, req_valid then 0, occupancy 4; release ready → in-order pop, no loss.
- 3 requests in flight (latency 3), redirect_pc=0x2000 → 3 stale responses dropped, next instr_pc 0x2000, no stale data observed.
- Redirect to 0x2002 → no request, one entry instr_misaligned=1 pc 0x2002, req_valid stays 0 until redirect to 0x3000 resumes fetch.
- fetch_pc 0xFFFFFFFC → next req_addr 0x00000000.
- cpu_rstn low for 1 cycle while occupancy 3, inflight 1 → all outputs at reset values next cycle, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Decoupled instruction-fetch front end: registered PC, credit-limited memory
// requests, in-order prefetch buffer, and redirect with flush of stale responses.
module fetch_unit #(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     ADDRWIDTH = 32,
  parameter int unsigned     DEPTH     = 4,
  parameter logic [XLEN-1:0] RESET_PC  = '0
) (
  input  logic                         clk,
  input  logic                         cpu_rstn,
  output logic                         req_valid,
  input  logic                         req_ready,
  output logic [ADDRWIDTH-1:0]         req_addr,
  input  logic                         rsp_valid,
  input  logic [XLEN-1:0]              rsp_data,
  input  logic                         redirect_valid,
  input  logic [XLEN-1:0]              redirect_pc,
  output logic                         instr_valid,
  input  logic                         instr_ready,
  output logic [XLEN-1:0]              instr_data,
  output logic [XLEN-1:0]              instr_pc,
  output logic                         instr_misaligned,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  typedef enum logic {FETCH, FAULT} state_t;
  state_t state, state_next;

  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   inflight, drop, count;
  logic [PW-1:0]   tag_wr, tag_rd, buf_wr, buf_rd;
  logic [XLEN-1:0] tag_q  [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH];
  logic [XLEN-1:0] pc_q   [DEPTH];
  logic [DEPTH-1:0] mis_q;
  logic [CW:0]     credit_used;
  logic            req_fire, push, pop, bad_redirect;

  assign credit_used  = {1'b0, count} + {1'b0, inflight};
  assign req_fire     = req_valid && req_ready;
  assign bad_redirect = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign push         = !redirect_valid && rsp_valid && (drop == '0);
  assign pop          = !redirect_valid && instr_valid && instr_ready;

  assign req_addr         = fetch_pc[ADDRWIDTH-1:0];
  assign occupancy        = count;
  assign instr_valid      = (count != '0);
  assign instr_data       = instr_valid ? data_q[buf_rd] : '0;
  assign instr_pc         = instr_valid ? pc_q[buf_rd]   : '0;
  assign instr_misaligned = instr_valid && mis_q[buf_rd];

  // Requests are gated by reset so none is offered while cpu_rstn is held low.
  always_comb begin
    state_next = state;
    req_valid  = 1'b0;
    if (redirect_valid) begin
      state_next = bad_redirect ? FAULT : FETCH;
    end else if (state == FETCH && cpu_rstn && credit_used < DEPTH_C) begin
      req_valid = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!cpu_rstn) begin
      state    <= FETCH;
      fetch_pc <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
      count    <= '0;
      tag_wr   <= '0;
      tag_rd   <= '0;
      buf_wr   <= '0;
      buf_rd   <= '0;
    end else begin
      state    <= state_next;
      inflight <= inflight + CW'(req_fire) - CW'(rsp_valid);
      if (req_fire)  tag_wr <= tag_wr + PW'(1);
      if (rsp_valid) tag_rd <= tag_rd + PW'(1);
      if (redirect_valid) begin
        // Everything still outstanding, minus a response landing now, is stale.
        fetch_pc <= redirect_pc;
        drop     <= inflight - CW'(rsp_valid);
        buf_rd   <= '0;
        buf_wr   <= bad_redirect ? PW'(1) : '0;
        count    <= bad_redirect ? CW'(1) : '0;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
        if (rsp_valid && drop != '0) drop <= drop - CW'(1);
        if (push) buf_wr <= buf_wr + PW'(1);
        if (pop)  buf_rd <= buf_rd + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) tag_q[tag_wr] <= fetch_pc;
    if (bad_redirect) begin
      data_q[0] <= '0;
      pc_q[0]   <= redirect_pc;
      mis_q[0]  <= 1'b1;
    end else if (push) begin
      data_q[buf_wr] <= rsp_data;
      pc_q[buf_wr]   <= tag_q[tag_rd];
      mis_q[buf_wr]  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: bench-side memory with configurable latency,
// recorded request and consumed-instruction streams checked against constants.
module tb_fetch_unit;
  localparam logic [31:0] MAGIC = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        cpu_rstn = 1'b0;
  logic        req_valid, req_ready = 1'b1;
  logic [31:0] req_addr;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid, instr_ready = 1'b1;
  logic [31:0] instr_data, instr_pc;
  logic        instr_misaligned;
  logic [2:0]  occupancy;

  fetch_unit #(.XLEN(32), .ADDRWIDTH(32), .DEPTH(4), .RESET_PC(32'h100)) dut (
    .clk(clk), .cpu_rstn(cpu_rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data),
    .instr_pc(instr_pc), .instr_misaligned(instr_misaligned), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] addr; logic [31:0] due; } mreq_t;
  mreq_t       mq[$];
  logic [31:0] reqs[$];
  logic [31:0] gpc[$];
  logic [31:0] gdata[$];
  logic        gmis[$];
  int unsigned edge_n = 0;
  int unsigned lat = 1;
  int n_tests = 0;
  int n_fail = 0;

  // One clock: present due response, sample handshakes, advance past the edge.
  task automatic tick();
    logic        hs;
    logic [31:0] ha;
    rsp_valid = 1'b0;
    rsp_data  = '0;
    if (mq.size() > 0 && mq[0].due <= edge_n + 1) begin
      rsp_valid = 1'b1;
      rsp_data  = mq[0].addr ^ MAGIC;
    end
    #2;
    hs = req_valid && req_ready;
    ha = req_addr;
    if (instr_valid && instr_ready && !redirect_valid && cpu_rstn) begin
      gpc.push_back(instr_pc);
      gdata.push_back(instr_data);
      gmis.push_back(instr_misaligned);
    end
    @(posedge clk);
    #1;
    edge_n++;
    if (rsp_valid) void'(mq.pop_front());
    rsp_valid = 1'b0;
    if (hs) begin
      mq.push_back('{addr: ha, due: edge_n + lat});
      reqs.push_back(ha);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_logs();
    reqs.delete(); gpc.delete(); gdata.delete(); gmis.delete();
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick();
    redirect_valid = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    mq.delete();
    cpu_rstn = 1'b0;
    tick();
    cpu_rstn = 1'b1;
    #1;
    clear_logs();
  endtask

  task automatic test_reset();
    cpu_rstn = 1'b0;
    ticks(2);
    n_tests++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b expected 0", req_valid); end
    n_tests++; if (req_addr !== 32'h100) begin n_fail++; $display("FAIL reset_req_addr: got %h expected 00000100", req_addr); end
    n_tests++; if (instr_valid !== 1'b0 || occupancy !== 3'd0) begin n_fail++; $display("FAIL reset_empty: got valid=%b occ=%0d expected valid=0 occ=0", instr_valid, occupancy); end
    n_tests++; if (instr_data !== 32'h0 || instr_pc !== 32'h0 || instr_misaligned !== 1'b0) begin n_fail++; $display("FAIL reset_instr: got data=%h pc=%h mis=%b expected zeros", instr_data, instr_pc, instr_misaligned); end
    cpu_rstn = 1'b1;
    #1;
    n_tests++; if (req_valid !== 1'b1) begin n_fail++; $display("FAIL first_req_valid: got %b expected 1", req_valid); end
    clear_logs();
  endtask

  task automatic test_stream();
    lat = 1; instr_ready = 1'b1;
    ticks(8);
    n_tests++; if (reqs.size() != 8 || reqs[0] !== 32'h100 || reqs[1] !== 32'h104 || reqs[3] !== 32'h10C) begin n_fail++; $display("FAIL stream_req_addr: got n=%0d %h %h %h expected n=8 00000100 00000104 0000010c", reqs.size(), reqs[0], reqs[1], reqs[3]); end
    n_tests++; if (gpc.size() != 6) begin n_fail++; $display("FAIL stream_throughput: got %0d instrs expected 6", gpc.size()); end
    n_tests++; if (gpc[0] !== 32'h100 || gpc[5] !== 32'h114) begin n_fail++; $display("FAIL stream_pc: got %h..%h expected 00000100..00000114", gpc[0], gpc[5]); end
    n_tests++; if (gdata[2] !== (32'h108 ^ MAGIC)) begin n_fail++; $display("FAIL stream_data: got %h expected %h", gdata[2], 32'h108 ^ MAGIC); end
  endtask

  task automatic test_backpressure();
    do_reset();
    lat = 1; instr_ready = 1'b0;
    ticks(10);
    n_tests++; if (reqs.size() != 4) begin n_fail++; $display("FAIL bp_req_count: got %0d expected 4", reqs.size()); end
    n_tests++; if (req_valid !== 1'b0 || occupancy !== 3'd4) begin n_fail++; $display("FAIL bp_full: got req_valid=%b occ=%0d expected 0 4", req_valid, occupancy); end
    n_tests++; if (instr_pc !== 32'h100 || instr_data !== (32'h100 ^ MAGIC)) begin n_fail++; $display("FAIL bp_hold: got pc=%h data=%h expected 00000100 %h", instr_pc, instr_data, 32'h100 ^ MAGIC); end
    instr_ready = 1'b1;
    ticks(6);
    n_tests++; if (gpc[0] !== 32'h100 || gpc[1] !== 32'h104 || gpc[2] !== 32'h108 || gpc[3] !== 32'h10C || gpc[4] !== 32'h110) begin n_fail++; $display("FAIL bp_order: got %h %h %h %h %h expected 100 104 108 10c 110", gpc[0], gpc[1], gpc[2], gpc[3], gpc[4]); end
    n_tests++; if (gdata[3] !== (32'h10C ^ MAGIC)) begin n_fail++; $display("FAIL bp_data: got %h expected %h", gdata[3], 32'h10C ^ MAGIC); end
  endtask

  task automatic test_redirect_drop();
    do_reset();
    lat = 3; instr_ready = 1'b1;
    ticks(3);
    n_tests++; if (reqs.size() != 3) begin n_fail++; $display("FAIL drop_setup: got %0d in flight expected 3", reqs.size()); end
    do_redirect(32'h2000);
    n_tests++; if (req_valid !== 1'b1 || req_addr !== 32'h2000) begin n_fail++; $display("FAIL drop_new_req: got valid=%b addr=%h expected 1 00002000", req_valid, req_addr); end
    ticks(3);
    n_tests++; if (gpc.size() != 0 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL drop_stale: got %0d instrs valid=%b expected 0 0", gpc.size(), instr_valid); end
    ticks(5);
    n_tests++; if (gpc[0] !== 32'h2000 || gpc[1] !== 32'h2004) begin n_fail++; $display("FAIL drop_first_pc: got %h %h expected 00002000 00002004", gpc[0], gpc[1]); end
    n_tests++; if (gdata[0] !== (32'h2000 ^ MAGIC)) begin n_fail++; $display("FAIL drop_first_data: got %h expected %h", gdata[0], 32'h2000 ^ MAGIC); end
  endtask

  task automatic test_misaligned();
    lat = 1; instr_ready = 1'b1;
    do_redirect(32'h2002);
    n_tests++; if (instr_valid !== 1'b1 || instr_misaligned !== 1'b1 || instr_pc !== 32'h2002 || instr_data !== 32'h0) begin n_fail++; $display("FAIL fault_marker: got v=%b mis=%b pc=%h data=%h expected 1 1 00002002 0", instr_valid, instr_misaligned, instr_pc, instr_data); end
    n_tests++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL fault_no_req: got %b expected 0", req_valid); end
    clear_logs();
    ticks(5);
    n_tests++; if (gpc.size() != 1 || gmis[0] !== 1'b1 || gpc[0] !== 32'h2002) begin n_fail++; $display("FAIL fault_single: got n=%0d mis=%b pc=%h expected 1 1 00002002", gpc.size(), gmis[0], gpc[0]); end
    n_tests++; if (req_valid !== 1'b0 || reqs.size() != 0 || occupancy !== 3'd0) begin n_fail++; $display("FAIL fault_hold: got valid=%b reqs=%0d occ=%0d expected 0 0 0", req_valid, reqs.size(), occupancy); end
    do_redirect(32'h3000);
    n_tests++; if (req_valid !== 1'b1 || req_addr !== 32'h3000) begin n_fail++; $display("FAIL fault_resume: got valid=%b addr=%h expected 1 00003000", req_valid, req_addr); end
    clear_logs();
    ticks(4);
    n_tests++; if (reqs[1] !== 32'h3004 || gpc[0] !== 32'h3000 || gmis[0] !== 1'b0) begin n_fail++; $display("FAIL fault_resume_stream: got req1=%h pc0=%h mis0=%b expected 00003004 00003000 0", reqs[1], gpc[0], gmis[0]); end
  endtask

  task automatic test_wrap();
    lat = 1; instr_ready = 1'b1;
    do_redirect(32'hFFFF_FFF8);
    clear_logs();
    ticks(6);
    n_tests++; if (reqs[1] !== 32'hFFFF_FFFC || reqs[2] !== 32'h0) begin n_fail++; $display("FAIL wrap_req: got %h %h expected fffffffc 00000000", reqs[1], reqs[2]); end
    n_tests++; if (gpc[1] !== 32'hFFFF_FFFC || gpc[2] !== 32'h0 || gdata[2] !== MAGIC) begin n_fail++; $display("FAIL wrap_instr: got %h %h data=%h expected fffffffc 00000000 %h", gpc[1], gpc[2], gdata[2], MAGIC); end
  endtask

  task automatic test_reset_midop();
    lat = 1; instr_ready = 1'b0;
    do_redirect(32'h4000);
    ticks(4);
    n_tests++; if (occupancy !== 3'd3 || mq.size() != 1) begin n_fail++; $display("FAIL midrst_setup: got occ=%0d inflight=%0d expected 3 1", occupancy, mq.size()); end
    mq.delete();
    cpu_rstn = 1'b0;
    tick();
    n_tests++; if (req_valid !== 1'b0 || req_addr !== 32'h100 || occupancy !== 3'd0) begin n_fail++; $display("FAIL midrst_state: got valid=%b addr=%h occ=%0d expected 0 00000100 0", req_valid, req_addr, occupancy); end
    n_tests++; if (instr_valid !== 1'b0 || instr_data !== 32'h0 || instr_pc !== 32'h0 || instr_misaligned !== 1'b0) begin n_fail++; $display("FAIL midrst_instr: got v=%b data=%h pc=%h mis=%b expected zeros", instr_valid, instr_data, instr_pc, instr_misaligned); end
    cpu_rstn = 1'b1;
    instr_ready = 1'b1;
    #1;
    clear_logs();
    ticks(4);
    n_tests++; if (reqs[0] !== 32'h100 || gpc[0] !== 32'h100 || gpc[1] !== 32'h104) begin n_fail++; $display("FAIL midrst_restart: got req0=%h pc0=%h pc1=%h expected 00000100 00000100 00000104", reqs[0], gpc[0], gpc[1]); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_drop();
    test_misaligned();
    test_wrap();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
